// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: owns the sprite position fed to the VGA overlay stage.
// The host programs shadow position/velocity/mode registers. Once per frame,
// at the first vblank pixel, a short FSM computes the next row, then the next
// column, and commits both together. The outputs therefore stay constant for
// the whole active region.
module sprite_motion_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int SPR_SIZE = 16,
    parameter int PW       = 10
) (
    input  logic          vga_clk,
    input  logic          vga_rst_n,
    input  logic [PW-1:0] pixel_row,
    input  logic [PW-1:0] pixel_col,
    input  logic          wr_en,
    input  logic [1:0]    wr_addr,
    input  logic [15:0]   wr_data,
    output logic [PW-1:0] spr_row,
    output logic [PW-1:0] spr_col,
    output logic          frame_tick,
    output logic [1:0]    edge_hit
);

    localparam int MAX_ROW = V_ACTIVE - SPR_SIZE;
    localparam int MAX_COL = H_ACTIVE - SPR_SIZE;
    // Two extra bits: one for the sign, one of headroom for pos + v.
    localparam int TW      = PW + 2;

    localparam logic [PW-1:0]        MAX_ROW_P = PW'(MAX_ROW);
    localparam logic [PW-1:0]        MAX_COL_P = PW'(MAX_COL);
    localparam logic signed [TW-1:0] MAX_ROW_S = TW'(MAX_ROW);
    localparam logic signed [TW-1:0] MAX_COL_S = TW'(MAX_COL);
    localparam logic signed [TW-1:0] ONE_S     = TW'(1);

    typedef enum logic [1:0] {IDLE, CALC_ROW, CALC_COL, COMMIT} state_t;

    // Result of one axis step. flip requests a velocity negation at commit.
    typedef struct packed {
        logic          edge_f;
        logic          flip;
        logic [PW-1:0] pos;
    } step_t;

    state_t state, nstate;

    logic [PW-1:0]      sh_row, sh_col;
    logic signed [7:0]  vy, vx;
    logic [1:0]         ctrl;
    logic               dirty_row, dirty_col;
    step_t              row_res, col_res;

    // Host positions are clamped to the legal top-left range.
    function automatic logic [PW-1:0] clamp_pos(input logic [PW-1:0] p,
                                                input logic [PW-1:0] maxp);
        return (p > maxp) ? maxp : p;
    endfunction

    // Velocity is held within +/-63, so one bounce or wrap always lands in range.
    function automatic logic signed [7:0] sat_v(input logic signed [7:0] b);
        if (b > 8'sd63)       return 8'sd63;
        else if (b < -8'sd63) return -8'sd63;
        else                  return b;
    endfunction

    // One axis: a dirty shadow position wins. Otherwise apply velocity if
    // motion is enabled, then bounce or wrap at the edges.
    function automatic step_t axis_step(input logic [PW-1:0]        cur,
                                        input logic [PW-1:0]        sh,
                                        input logic                 dirty,
                                        input logic signed [7:0]    v,
                                        input logic                 en,
                                        input logic                 wrap,
                                        input logic signed [TW-1:0] maxp);
        logic signed [TW-1:0] t, neg_t, refl, wlo, whi;
        step_t r;
        r      = '0;
        r.pos  = cur;
        t      = $signed({2'b00, cur}) + $signed({{(TW-8){v[7]}}, v});
        neg_t  = -t;
        refl   = (maxp <<< 1) - t;
        wlo    = t + maxp + ONE_S;
        whi    = t - maxp - ONE_S;
        if (dirty) begin
            r.pos = sh;
        end else if (en) begin
            r.pos = t[PW-1:0];
            if (t < 0) begin
                r.edge_f = 1'b1;
                r.flip   = !wrap;
                r.pos    = wrap ? wlo[PW-1:0] : neg_t[PW-1:0];
            end else if (t > maxp) begin
                r.edge_f = 1'b1;
                r.flip   = !wrap;
                r.pos    = wrap ? whi[PW-1:0] : refl[PW-1:0];
            end
        end
        return r;
    endfunction

    // State register
    always_ff @(posedge vga_clk) begin
        if (!vga_rst_n) state <= IDLE;
        else            state <= nstate;
    end

    // Next state; frame_tick and edge_hit are asserted only during COMMIT
    always_comb begin
        nstate     = state;
        frame_tick = 1'b0;
        edge_hit   = 2'b00;
        case (state)
            IDLE: begin
                if (pixel_row == PW'(V_ACTIVE) && pixel_col == '0) nstate = CALC_ROW;
            end
            CALC_ROW: nstate = CALC_COL;
            CALC_COL: nstate = COMMIT;
            COMMIT: begin
                nstate     = IDLE;
                frame_tick = 1'b1;
                edge_hit   = {row_res.edge_f, col_res.edge_f};
            end
            default: nstate = IDLE;
        endcase
    end

    // Datapath. The host write comes last so that it overrides the COMMIT
    // velocity write-back and dirty clear for the same register.
    always_ff @(posedge vga_clk) begin
        if (!vga_rst_n) begin
            spr_row   <= '0;
            spr_col   <= '0;
            sh_row    <= '0;
            sh_col    <= '0;
            vy        <= '0;
            vx        <= '0;
            ctrl      <= '0;
            dirty_row <= 1'b0;
            dirty_col <= 1'b0;
            row_res   <= '0;
            col_res   <= '0;
        end else begin
            case (state)
                CALC_ROW: row_res <= axis_step(spr_row, sh_row, dirty_row, vy,
                                               ctrl[0], ctrl[1], MAX_ROW_S);
                CALC_COL: col_res <= axis_step(spr_col, sh_col, dirty_col, vx,
                                               ctrl[0], ctrl[1], MAX_COL_S);
                COMMIT: begin
                    spr_row   <= row_res.pos;
                    spr_col   <= col_res.pos;
                    if (row_res.flip) vy <= -vy;
                    if (col_res.flip) vx <= -vx;
                    dirty_row <= 1'b0;
                    dirty_col <= 1'b0;
                end
                default: ;
            endcase
            if (wr_en) begin
                case (wr_addr)
                    2'd0: begin
                        sh_row    <= clamp_pos(wr_data[PW-1:0], MAX_ROW_P);
                        dirty_row <= 1'b1;
                    end
                    2'd1: begin
                        sh_col    <= clamp_pos(wr_data[PW-1:0], MAX_COL_P);
                        dirty_col <= 1'b1;
                    end
                    2'd2: begin
                        vy <= sat_v(wr_data[15:8]);
                        vx <= sat_v(wr_data[7:0]);
                    end
                    default: ctrl <= wr_data[1:0];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Scoreboard bench for sprite_motion_ctrl. Each frame strobe pushes the
// hand-computed commit into a queue. The monitor pops an entry on every
// frame_tick and checks tick timing, edge_hit, held outputs and new outputs.
module tb_sprite_motion_ctrl;

    logic        vga_clk = 1'b0;
    logic        vga_rst_n;
    logic [9:0]  pixel_row, pixel_col;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [15:0] wr_data;
    logic [9:0]  spr_row, spr_col;
    logic        frame_tick;
    logic [1:0]  edge_hit;

    sprite_motion_ctrl dut (
        .vga_clk   (vga_clk),
        .vga_rst_n (vga_rst_n),
        .pixel_row (pixel_row),
        .pixel_col (pixel_col),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .spr_row   (spr_row),
        .spr_col   (spr_col),
        .frame_tick(frame_tick),
        .edge_hit  (edge_hit)
    );

    always #5 vga_clk = ~vga_clk;

    int cyc = 0;
    always @(posedge vga_clk) cyc <= cyc + 1;

    typedef struct {
        int         tcyc;
        logic [1:0] e;
        int         prow, pcol, row, col;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   last_row = 0;
    int   last_col = 0;

    function automatic void chk(input string nm, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endfunction

    // Monitor: any tick with an empty scoreboard is a failure.
    initial begin
        exp_t e;
        forever begin
            @(negedge vga_clk);
            if (frame_tick) begin
                if (sb.size() == 0) begin
                    chk("unexpected_tick", cyc, -1);
                end else begin
                    e = sb.pop_front();
                    chk("tick_cycle", cyc, e.tcyc);
                    chk("edge_hit", int'(edge_hit), int'(e.e));
                    chk("row_held", int'(spr_row), e.prow);
                    chk("col_held", int'(spr_col), e.pcol);
                    @(negedge vga_clk);
                    chk("row_commit", int'(spr_row), e.row);
                    chk("col_commit", int'(spr_col), e.col);
                end
            end
        end
    end

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        @(negedge vga_clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge vga_clk);
        wr_en = 1'b0;
    endtask

    // One frame boundary. Optionally issues a host write in the COMMIT cycle,
    // or asserts reset while the FSM is in CALC_COL (no commit expected).
    task automatic vblank(input int r, input int c, input logic [1:0] e,
                          input bit cw = 1'b0, input logic [1:0] ca = 2'd0,
                          input logic [15:0] cd = 16'd0, input bit crst = 1'b0);
        @(negedge vga_clk);
        pixel_row = 10'd480; pixel_col = 10'd0;
        if (!crst) begin
            sb.push_back('{cyc + 3, e, last_row, last_col, r, c});
            last_row = r; last_col = c;
        end
        @(negedge vga_clk);
        pixel_row = 10'd12; pixel_col = 10'd7;
        @(negedge vga_clk);
        if (crst) vga_rst_n = 1'b0;
        @(negedge vga_clk);
        if (cw) begin wr_en = 1'b1; wr_addr = ca; wr_data = cd; end
        @(negedge vga_clk);
        wr_en = 1'b0;
        repeat (3) @(negedge vga_clk);
        if (crst) begin
            vga_rst_n = 1'b1;
            last_row = 0; last_col = 0;
        end
    endtask

    initial begin
        vga_rst_n = 1'b0; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 16'd0;
        pixel_row = 10'd0; pixel_col = 10'd0;

        // Two frames in reset: no tick, outputs at zero
        repeat (2) begin
            @(negedge vga_clk);
            pixel_row = 10'd480; pixel_col = 10'd0;
            @(negedge vga_clk);
            pixel_row = 10'd0; pixel_col = 10'd1;
            repeat (6) @(negedge vga_clk);
        end
        chk("rst_row", int'(spr_row), 0);
        chk("rst_col", int'(spr_col), 0);
        chk("rst_tick", int'(frame_tick), 0);
        chk("rst_edge", int'(edge_hit), 0);
        @(negedge vga_clk);
        vga_rst_n = 1'b1;
        vblank(0, 0, 2'b00);
        vblank(0, 0, 2'b00);

        // Position writes; outputs hold until the commit, and col is clamped
        wr(2'd0, 16'd100); wr(2'd1, 16'd200);
        chk("wr_hold_row", int'(spr_row), 0);
        chk("wr_hold_col", int'(spr_col), 0);
        vblank(100, 200, 2'b00);
        wr(2'd1, 16'd700);
        vblank(100, 624, 2'b00);

        // Linear motion: v = (+3, -2)
        wr(2'd0, 16'd10); wr(2'd1, 16'd10);
        vblank(10, 10, 2'b00);
        wr(2'd2, 16'h03FE); wr(2'd3, 16'd1);
        vblank(13, 8, 2'b00);
        vblank(16, 6, 2'b00);
        vblank(19, 4, 2'b00);
        vblank(22, 2, 2'b00);

        // Bounce on both axes, then the negated velocities carry on
        wr(2'd3, 16'd0); wr(2'd0, 16'd2); wr(2'd1, 16'd620); wr(2'd2, 16'hFB0A);
        vblank(2, 620, 2'b00);
        wr(2'd3, 16'd1);
        vblank(3, 618, 2'b11);
        vblank(8, 608, 2'b00);

        // Wrap on both axes; velocity unchanged afterwards
        wr(2'd3, 16'd0); wr(2'd0, 16'd1); wr(2'd1, 16'd620); wr(2'd2, 16'hFC0A);
        vblank(1, 620, 2'b00);
        wr(2'd3, 16'd3);
        vblank(462, 5, 2'b11);
        vblank(458, 15, 2'b00);

        // Velocity saturation: dy = -100 -> -63, dx = +100 -> +63
        wr(2'd3, 16'd0); wr(2'd0, 16'd100); wr(2'd1, 16'd100); wr(2'd2, 16'h9C64);
        vblank(100, 100, 2'b00);
        wr(2'd3, 16'd1);
        vblank(37, 163, 2'b00);

        // Collisions: host velocity and host row writes in the COMMIT cycle win
        wr(2'd3, 16'd0); wr(2'd0, 16'd100); wr(2'd1, 16'd620); wr(2'd2, 16'h000A);
        vblank(100, 620, 2'b00);
        wr(2'd3, 16'd1);
        vblank(100, 618, 2'b01, 1'b1, 2'd2, 16'h0003);
        vblank(100, 621, 2'b00, 1'b1, 2'd0, 16'd50);
        vblank(50, 624, 2'b00);
        vblank(50, 621, 2'b01);

        // Reset during CALC_COL aborts the commit
        vblank(0, 0, 2'b00, 1'b0, 2'd0, 16'd0, 1'b1);
        chk("abort_row", int'(spr_row), 0);
        chk("abort_col", int'(spr_col), 0);
        vblank(0, 0, 2'b00);

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge vga_clk);
        if (sb.size() != 0) chk("scoreboard_drain", sb.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
